// File: rtl/fpu_issue_queue_if.sv
// Issue/commit/dispatch bundle between the XIF side and the FPU model input stage.
interface fpu_issue_queue_if #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned XLEN       = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                  issue_valid;
    logic                  issue_ready;
    logic [31:0]           issue_instr;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic [XLEN-1:0]       issue_rs;
    logic                  issue_accept;
    logic                  commit_valid;
    logic [X_ID_WIDTH-1:0] commit_id;
    logic                  commit_kill;
    logic                  fpu_stall;
    logic                  fpu_enable;
    logic [31:0]           fpu_instruction;
    logic [X_ID_WIDTH-1:0] fpu_id;
    logic [XLEN-1:0]       fpu_data_fromXreg;
    logic [CNT_W-1:0]      count;

    modport slave (
        input  issue_valid, issue_instr, issue_id, issue_rs,
        input  commit_valid, commit_id, commit_kill, fpu_stall,
        output issue_ready, issue_accept,
        output fpu_enable, fpu_instruction, fpu_id, fpu_data_fromXreg, count
    );

    modport master (
        output issue_valid, issue_instr, issue_id, issue_rs,
        output commit_valid, commit_id, commit_kill, fpu_stall,
        input  issue_ready, issue_accept,
        input  fpu_enable, fpu_instruction, fpu_id, fpu_data_fromXreg, count
    );
endinterface

// File: rtl/fpu_issue_queue.sv
// In-order issue queue: buffers accepted FP instructions, tracks commit/kill per id,
// and dispatches committed heads to the FPU model while it is not stalled.
module fpu_issue_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned XLEN       = 32
) (
    input  logic               ck,
    input  logic               rst_n,
    fpu_issue_queue_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      cmt_q, cmt_d;
    logic [DEPTH-1:0]      kill_q, kill_d;
    logic [31:0]           instr_q [DEPTH];
    logic [31:0]           instr_d [DEPTH];
    logic [X_ID_WIDTH-1:0] id_q [DEPTH];
    logic [X_ID_WIDTH-1:0] id_d [DEPTH];
    logic [XLEN-1:0]       rs_q [DEPTH];
    logic [XLEN-1:0]       rs_d [DEPTH];

    logic                  fpu_enable_q, fpu_enable_d;
    logic [31:0]           fpu_instr_q, fpu_instr_d;
    logic [X_ID_WIDTH-1:0] fpu_id_q, fpu_id_d;
    logic [XLEN-1:0]       fpu_data_q, fpu_data_d;

    logic                  issue_ready_c;
    logic                  issue_accept_c;
    logic                  push;
    logic                  pop;

    assign issue_ready_c = rst_n && (count_q < CNT_W'(DEPTH));

    // Opcode filter: only the F/D load/store/fused/op major opcodes are ours.
    always_comb begin
        issue_accept_c = 1'b0;
        case (bus.issue_instr[6:0])
            7'h07, 7'h27, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53: issue_accept_c = 1'b1;
            default:                                          issue_accept_c = 1'b0;
        endcase
    end

    // Next state: head pop/dispatch, enqueue, then commit/kill marking on the resulting contents.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        valid_d      = valid_q;
        cmt_d        = cmt_q;
        kill_d       = kill_q;
        instr_d      = instr_q;
        id_d         = id_q;
        rs_d         = rs_q;
        fpu_enable_d = 1'b0;
        fpu_instr_d  = fpu_instr_q;
        fpu_id_d     = fpu_id_q;
        fpu_data_d   = fpu_data_q;
        push         = bus.issue_valid && issue_ready_c && issue_accept_c;
        pop          = 1'b0;

        // Head decision sees only pre-edge flags; a same-cycle commit acts next cycle.
        if (count_q != '0) begin
            if (kill_q[rd_ptr_q]) begin
                pop = 1'b1;
            end else if (cmt_q[rd_ptr_q] && !bus.fpu_stall) begin
                pop          = 1'b1;
                fpu_enable_d = 1'b1;
                fpu_instr_d  = instr_q[rd_ptr_q];
                fpu_id_d     = id_q[rd_ptr_q];
                fpu_data_d   = rs_q[rd_ptr_q];
            end
        end

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            cmt_d[rd_ptr_q]   = 1'b0;
            kill_d[rd_ptr_q]  = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            cmt_d[wr_ptr_q]   = 1'b0;
            kill_d[wr_ptr_q]  = 1'b0;
            instr_d[wr_ptr_q] = bus.issue_instr;
            id_d[wr_ptr_q]    = bus.issue_id;
            rs_d[wr_ptr_q]    = bus.issue_rs;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end

        // Marking after the enqueue lets a commit hit an entry issued in the same cycle.
        if (bus.commit_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_d[PTR_W'(i)] && (id_d[PTR_W'(i)] == bus.commit_id)) begin
                    if (bus.commit_kill) begin
                        kill_d[PTR_W'(i)] = 1'b1;
                    end else begin
                        cmt_d[PTR_W'(i)]  = 1'b1;
                    end
                end
            end
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // State and output registers.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            cmt_q        <= '0;
            kill_q       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                id_q[i]    <= '0;
                rs_q[i]    <= '0;
            end
            fpu_enable_q <= 1'b0;
            fpu_instr_q  <= '0;
            fpu_id_q     <= '0;
            fpu_data_q   <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            cmt_q        <= cmt_d;
            kill_q       <= kill_d;
            instr_q      <= instr_d;
            id_q         <= id_d;
            rs_q         <= rs_d;
            fpu_enable_q <= fpu_enable_d;
            fpu_instr_q  <= fpu_instr_d;
            fpu_id_q     <= fpu_id_d;
            fpu_data_q   <= fpu_data_d;
        end
    end

    assign bus.issue_ready       = issue_ready_c;
    assign bus.issue_accept      = issue_accept_c;
    assign bus.fpu_enable        = fpu_enable_q;
    assign bus.fpu_instruction   = fpu_instr_q;
    assign bus.fpu_id            = fpu_id_q;
    assign bus.fpu_data_fromXreg = fpu_data_q;
    assign bus.count             = count_q;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Bench for fpu_issue_queue: directed scenarios plus random traffic against an in-order scoreboard.
module tb_fpu_issue_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XW    = 4;
    localparam int unsigned XL    = 32;

    typedef struct {
        logic [31:0]   instr;
        logic [XW-1:0] id;
        logic [XL-1:0] rs;
        bit            c;
        bit            k;
    } ent_t;

    logic ck = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   pulses = 0;
    logic [XW-1:0] last_id = '0;

    ent_t pend[$];   // issued entries whose fate is still open, in program order
    ent_t exp_q[$];  // committed entries awaiting dispatch, in program order

    fpu_issue_queue_if #(.DEPTH(DEPTH), .X_ID_WIDTH(XW), .XLEN(XL)) bus ();

    fpu_issue_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(XW), .XLEN(XL)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 ck = ~ck;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic bit is_fp(input logic [31:0] instr);
        logic [6:0] op;
        op = instr[6:0];
        return (op == 7'h07) || (op == 7'h27) || (op == 7'h43) || (op == 7'h47) ||
               (op == 7'h4B) || (op == 7'h4F) || (op == 7'h53);
    endfunction

    function automatic void model_issue(input logic [31:0] instr, input logic [XW-1:0] id,
                                        input logic [XL-1:0] rs);
        ent_t e;
        if (is_fp(instr)) begin
            e.instr = instr; e.id = id; e.rs = rs; e.c = 1'b0; e.k = 1'b0;
            pend.push_back(e);
        end
    endfunction

    // Once the oldest open entry is decided, its outcome (dispatch or drop) is fixed in order.
    function automatic void model_commit(input logic [XW-1:0] id, input bit kill);
        ent_t e;
        foreach (pend[i]) begin
            if (pend[i].id == id) begin
                if (kill) pend[i].k = 1'b1;
                else      pend[i].c = 1'b1;
            end
        end
        while (pend.size() > 0 && (pend[0].c || pend[0].k)) begin
            e = pend.pop_front();
            if (!e.k) exp_q.push_back(e);
        end
    endfunction

    // Monitor: every dispatch pulse must match the oldest expected entry.
    always @(posedge ck) begin
        ent_t e;
        #1;
        if (rst_n && bus.fpu_enable) begin
            pulses++;
            last_id = bus.fpu_id;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_dispatch: id 0x%0h instr 0x%0h with nothing expected",
                         bus.fpu_id, bus.fpu_instruction);
            end else begin
                e = exp_q.pop_front();
                check("disp_instr", 64'(bus.fpu_instruction), 64'(e.instr));
                check("disp_id", 64'(bus.fpu_id), 64'(e.id));
                check("disp_rs", 64'(bus.fpu_data_fromXreg), 64'(e.rs));
            end
        end
    end

    // Drive one cycle of issue/commit starting just after a negedge; returns at the next negedge.
    task automatic step(input bit iv, input logic [31:0] instr, input logic [XW-1:0] id,
                        input logic [XL-1:0] rs, input bit cv, input logic [XW-1:0] cid,
                        input bit kl, output bit hs);
        bus.issue_valid = iv;
        bus.issue_instr = instr;
        bus.issue_id    = id;
        bus.issue_rs    = rs;
        bus.commit_valid = cv;
        bus.commit_id   = cid;
        bus.commit_kill = kl;
        #1;
        hs = iv && bus.issue_ready;
        if (iv) check("issue_accept", 64'(bus.issue_accept), 64'(is_fp(instr)));
        if (hs) model_issue(instr, id, rs);
        if (cv) model_commit(cid, kl);
        @(negedge ck);
        bus.issue_valid  = 1'b0;
        bus.commit_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || bus.count != 0) && n < 100) begin
            @(negedge ck);
            n++;
        end
        check(nm, 64'(exp_q.size() == 0 && bus.count == 0), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit            hs;
        int            p0;
        int            cnt0;
        logic [XW-1:0] next_id;
        logic [31:0]   r;
        logic [31:0]   instr;
        logic [6:0]    op;
        bit            iv;
        int            cand[$];
        int            pick;
        logic [6:0]    fp_ops [7];

        fp_ops = '{7'h07, 7'h27, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53};
        rst_n = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_instr = '0; bus.issue_id = '0; bus.issue_rs = '0;
        bus.commit_valid = 1'b0; bus.commit_id = '0; bus.commit_kill = 1'b0; bus.fpu_stall = 1'b0;
        @(negedge ck);
        #1 check("ready_in_reset", 64'(bus.issue_ready), 64'(0));
        @(negedge ck);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 64'(bus.issue_ready), 64'(1));
        check("count_after_reset", 64'(bus.count), 64'(0));
        check("enable_after_reset", 64'(bus.fpu_enable), 64'(0));
        check("instr_after_reset", 64'(bus.fpu_instruction), 64'(0));
        check("id_after_reset", 64'(bus.fpu_id), 64'(0));
        check("data_after_reset", 64'(bus.fpu_data_fromXreg), 64'(0));

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) step(1, 32'h0000_0053, XW'(i), 32'(i + 100), 0, '0, 0, hs);
        check("count_three", 64'(bus.count), 64'(3));
        rst_n = 1'b0;
        #1;
        check("count_reset_mid", 64'(bus.count), 64'(0));
        check("enable_reset_mid", 64'(bus.fpu_enable), 64'(0));
        check("ready_reset_mid", 64'(bus.issue_ready), 64'(0));
        pend.delete();
        exp_q.delete();
        @(negedge ck);
        rst_n = 1'b1;
        #1 check("ready_release", 64'(bus.issue_ready), 64'(1));

        // Issue+commit in the same cycle: pulse two edges later.
        p0 = pulses;
        step(1, 32'h0020_8053, 4'd3, 32'hCAFE_0003, 1, 4'd3, 0, hs);
        check("lat_not_yet", 64'(bus.fpu_enable), 64'(0));
        @(negedge ck);
        check("lat_enable", 64'(bus.fpu_enable), 64'(1));
        check("lat_instr", 64'(bus.fpu_instruction), 64'h0020_8053);
        check("lat_id", 64'(bus.fpu_id), 64'(3));
        @(negedge ck);
        check("lat_one_pulse", 64'(bus.fpu_enable), 64'(0));
        check("lat_pulse_count", 64'(pulses - p0), 64'(1));

        // Fill to DEPTH with uncommitted entries.
        for (int i = 0; i < 4; i++) step(1, 32'h0000_1053, XW'(i), 32'(i + 200), 0, '0, 0, hs);
        check("full_count", 64'(bus.count), 64'(4));
        check("full_ready", 64'(bus.issue_ready), 64'(0));
        step(1, 32'h0000_2053, 4'd4, 32'd204, 0, '0, 0, hs);
        check("fifth_held", 64'(bus.count), 64'(4));
        step(0, '0, '0, '0, 1, 4'd0, 0, hs);
        @(negedge ck);
        check("after_commit0_ready", 64'(bus.issue_ready), 64'(1));
        check("after_commit0_count", 64'(bus.count), 64'(3));
        for (int i = 1; i < 4; i++) step(0, '0, '0, '0, 1, XW'(i), 1, hs);
        wait_drain("drain_full");

        // Kill one, commit the next.
        p0 = pulses;
        step(1, 32'h0000_0043, 4'd1, 32'd301, 0, '0, 0, hs);
        step(1, 32'h0000_0047, 4'd2, 32'd302, 0, '0, 0, hs);
        step(0, '0, '0, '0, 1, 4'd1, 1, hs);
        step(0, '0, '0, '0, 1, 4'd2, 0, hs);
        wait_drain("drain_kill");
        repeat (2) @(negedge ck);
        check("kill_pulses", 64'(pulses - p0), 64'(1));
        check("kill_last_id", 64'(last_id), 64'(2));

        // Stall holds two committed entries, then they go back to back.
        p0 = pulses;
        bus.fpu_stall = 1'b1;
        step(1, 32'h0000_0007, 4'd4, 32'd404, 1, 4'd4, 0, hs);
        step(1, 32'h0000_0027, 4'd5, 32'd405, 1, 4'd5, 0, hs);
        repeat (3) @(negedge ck);
        check("stall_no_pulse", 64'(pulses - p0), 64'(0));
        check("stall_count", 64'(bus.count), 64'(2));
        bus.fpu_stall = 1'b0;
        @(negedge ck);
        check("b2b_first_en", 64'(bus.fpu_enable), 64'(1));
        check("b2b_first_id", 64'(bus.fpu_id), 64'(4));
        @(negedge ck);
        check("b2b_second_en", 64'(bus.fpu_enable), 64'(1));
        check("b2b_second_id", 64'(bus.fpu_id), 64'(5));
        @(negedge ck);
        check("b2b_done", 64'(bus.fpu_enable), 64'(0));
        check("b2b_count", 64'(bus.count), 64'(0));

        // Non-FP reject, unmatched commit, and out-of-order commit.
        cnt0 = int'(bus.count);
        step(1, 32'h0000_0033, 4'd6, 32'd606, 1, 4'd9, 0, hs);
        check("reject_handshake", 64'(hs), 64'(1));
        @(negedge ck);
        check("reject_count", 64'(bus.count), 64'(cnt0));
        p0 = pulses;
        step(1, 32'h0000_004F, 4'd1, 32'd701, 0, '0, 0, hs);
        step(1, 32'h0000_004B, 4'd2, 32'd702, 0, '0, 0, hs);
        step(0, '0, '0, '0, 1, 4'd2, 0, hs);
        repeat (3) @(negedge ck);
        check("ooo_blocked", 64'(pulses - p0), 64'(0));
        step(0, '0, '0, '0, 1, 4'd1, 0, hs);
        wait_drain("drain_ooo");
        repeat (2) @(negedge ck);
        check("ooo_pulses", 64'(pulses - p0), 64'(2));

        // Random traffic.
        next_id = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r  = $urandom();
            iv = (r[1:0] != 2'b00);
            if (r[4:2] == 3'd0) op = 7'h33;
            else if (r[4:2] == 3'd1) op = 7'(r[11:5]);
            else op = fp_ops[$urandom_range(0, 6)];
            r = $urandom();
            instr = {r[31:7], op};
            bus.issue_valid  = iv;
            bus.issue_instr  = instr;
            bus.issue_id     = next_id;
            bus.issue_rs     = $urandom();
            bus.fpu_stall    = ($urandom_range(0, 3) == 0);
            #1;
            hs = iv && bus.issue_ready;
            if (iv) check("rnd_accept", 64'(bus.issue_accept), 64'(is_fp(instr)));
            if (hs) begin
                model_issue(instr, next_id, bus.issue_rs);
                if (is_fp(instr)) next_id = next_id + XW'(1);
            end
            cand.delete();
            foreach (pend[i]) if (!pend[i].c && !pend[i].k) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                pick = cand[$urandom_range(0, cand.size() - 1)];
                bus.commit_valid = 1'b1;
                bus.commit_id    = pend[pick].id;
                bus.commit_kill  = ($urandom_range(0, 4) == 0);
                model_commit(bus.commit_id, bus.commit_kill);
            end
            @(negedge ck);
            bus.issue_valid  = 1'b0;
            bus.commit_valid = 1'b0;
            if (bus.count > 3'(DEPTH)) check("rnd_count_bound", 64'(bus.count), 64'(DEPTH));
        end
        bus.fpu_stall = 1'b0;
        for (int n = 0; n < 20 && pend.size() > 0; n++)
            step(0, '0, '0, '0, 1, pend[0].id, 0, hs);
        check("rnd_pend_empty", 64'(pend.size()), 64'(0));
        wait_drain("drain_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
